// File: rtl/frequency_analysis_scheduler.sv
// Measurement-window sequencer for the frequency analyzer bank: clear, enable,
// drain result words through a valid/ready register write, then interrupt.
module frequency_analysis_scheduler #(
    parameter int unsigned RESULTS_NUMBER = 7,
    parameter int unsigned REGISTER_BASE  = 1,
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned WINDOW_WIDTH   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    continuous,
    input  logic [WINDOW_WIDTH-1:0] window_cycles,
    output logic                    analyzer_clear_n,
    output logic                    analyzer_enable,
    output logic [3:0]              result_index,
    input  logic [31:0]             result_data,
    output logic                    reg_write_valid,
    input  logic                    reg_write_ready,
    output logic [7:0]              reg_number,
    output logic [31:0]             reg_value,
    output logic                    irq,
    input  logic                    irq_ack,
    output logic                    busy,
    output logic                    overrun,
    output logic [15:0]             measurement_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0]              LAST_INDEX = 4'(RESULTS_NUMBER - 1);
    localparam logic [WINDOW_WIDTH-1:0] CLEAR_LOAD = WINDOW_WIDTH'(CLEAR_CYCLES - 1);

    state_t                  state, state_next;
    logic [WINDOW_WIDTH-1:0] cnt, cnt_next;
    logic [WINDOW_WIDTH-1:0] window_q, window_next;
    logic [3:0]              index_q, index_next;
    logic                    abort_pending, abort_pending_next;
    logic                    overrun_next;
    logic [15:0]             count_next;
    logic                    handshake;

    assign handshake = reg_write_valid && reg_write_ready;

    // State, counters and registered outputs (outputs follow the next state)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            window_q          <= '0;
            index_q           <= '0;
            abort_pending     <= 1'b0;
            analyzer_clear_n  <= 1'b1;
            analyzer_enable   <= 1'b0;
            result_index      <= '0;
            reg_write_valid   <= 1'b0;
            reg_number        <= '0;
            reg_value         <= '0;
            irq               <= 1'b0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            measurement_count <= '0;
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            window_q          <= window_next;
            index_q           <= index_next;
            abort_pending     <= abort_pending_next;
            analyzer_clear_n  <= (state_next != S_CLEAR);
            analyzer_enable   <= (state_next == S_MEASURE);
            result_index      <= index_next;
            reg_write_valid   <= (state_next == S_WRITE);
            irq               <= (state_next == S_DONE);
            busy              <= (state_next != S_IDLE);
            overrun           <= overrun_next;
            measurement_count <= count_next;
            // Capture the settled mux word once, on entry to WRITE
            if (state_next == S_WRITE && state != S_WRITE) begin
                reg_number <= 8'(REGISTER_BASE) + 8'(index_next);
                reg_value  <= result_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        window_next        = window_q;
        index_next         = index_q;
        abort_pending_next = abort_pending;
        overrun_next       = overrun;
        count_next         = measurement_count;

        case (state)
            S_IDLE: begin
                if (arm && !abort && window_cycles != '0) begin
                    state_next   = S_CLEAR;
                    cnt_next     = CLEAR_LOAD;
                    window_next  = window_cycles;
                    overrun_next = 1'b0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_MEASURE;
                    cnt_next   = window_q - WINDOW_WIDTH'(1);
                end else begin
                    cnt_next = cnt - WINDOW_WIDTH'(1);
                end
            end
            S_MEASURE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_FETCH;
                    index_next = '0;
                end else begin
                    cnt_next = cnt - WINDOW_WIDTH'(1);
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    state_next         = S_WRITE;
                    abort_pending_next = 1'b0;
                end
            end
            S_WRITE: begin
                // A pending write is never withdrawn; abort takes effect after it
                if (abort) begin
                    abort_pending_next = 1'b1;
                end
                if (handshake) begin
                    if (abort || abort_pending) begin
                        state_next = S_IDLE;
                    end else if (index_q == LAST_INDEX) begin
                        state_next = S_DONE;
                        count_next = measurement_count + 16'(1);
                    end else begin
                        state_next = S_FETCH;
                        index_next = index_q + 4'(1);
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (irq_ack) begin
                    if (continuous && window_cycles != '0) begin
                        state_next  = S_CLEAR;
                        cnt_next    = CLEAR_LOAD;
                        window_next = window_cycles;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (state != S_IDLE && arm) begin
            overrun_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_frequency_analysis_scheduler.sv
// Directed bench for frequency_analysis_scheduler (C=4, N=7, base 1).
module tb_frequency_analysis_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm, abort, continuous, reg_write_ready, irq_ack;
    logic [31:0] window_cycles;
    logic        analyzer_clear_n, analyzer_enable, reg_write_valid, irq, busy, overrun;
    logic [3:0]  result_index;
    logic [31:0] result_data;
    logic [7:0]  reg_number;
    logic [31:0] reg_value;
    logic [15:0] measurement_count;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mux_val(input int i);
        return 32'hC0DE_0000 + 32'(i * 3);
    endfunction

    assign result_data = mux_val(int'(result_index));

    frequency_analysis_scheduler dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort), .continuous(continuous),
        .window_cycles(window_cycles), .analyzer_clear_n(analyzer_clear_n),
        .analyzer_enable(analyzer_enable), .result_index(result_index),
        .result_data(result_data), .reg_write_valid(reg_write_valid),
        .reg_write_ready(reg_write_ready), .reg_number(reg_number), .reg_value(reg_value),
        .irq(irq), .irq_ack(irq_ack), .busy(busy), .overrun(overrun),
        .measurement_count(measurement_count)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
        reg_write_ready = 1'b1; irq_ack = 1'b0; window_cycles = 32'd10;
        step(); step();
        reset = 1'b0;
        cyc = 0;
    endtask

    // Arm at cycle 0; edge 0 samples it
    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Full W=10 run with `stall` not-ready cycles ahead of each accepted write
    task automatic run_check(input int stall, input int last);
        int p, rel, widx, last_valid;
        logic e_clr, e_en, e_val, e_irq;
        p = stall + 2;
        last_valid = 16 + 6 * p + stall;
        arm_pulse();
        for (int j = 1; j <= last; j++) begin
            rel   = j - 16;
            widx  = (rel >= 0) ? rel / p : 0;
            e_clr = !(j >= 1 && j <= 4);
            e_en  = (j >= 5 && j <= 14);
            e_val = (rel >= 0) && (widx <= 6) && (rel % p <= stall);
            e_irq = (j > last_valid);
            reg_write_ready = e_val && (rel % p == stall);
            chk("ctl{clr,en,val,irq}", 96'({analyzer_clear_n, analyzer_enable, reg_write_valid, irq}),
                96'({e_clr, e_en, e_val, e_irq}));
            if (e_val) begin
                chk("reg_number", 96'(reg_number), 96'(1 + widx));
                chk("reg_value", 96'(reg_value), 96'(mux_val(widx)));
            end
            step();
        end
        reg_write_ready = 1'b1;
        chk("count_after_run", 96'(measurement_count), 96'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ack_idle{irq,busy}", 96'({irq, busy}), 96'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk("reset_outputs", 96'({analyzer_clear_n, analyzer_enable, result_index, reg_write_valid,
                                  reg_number, reg_value, irq, busy, overrun, measurement_count}),
            96'({1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}));

        // Nominal run, ready always high: irq at cycle 29
        run_check(0, 29);

        // Same run with 3 stall cycles per write: irq at cycle 50
        do_reset();
        run_check(3, 50);

        // Abort during MEASURE
        do_reset();
        arm_pulse();
        step_to(8);
        chk("measure_en_before_abort", 96'(analyzer_enable), 96'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_measure{en,busy,clr}", 96'({analyzer_enable, busy, analyzer_clear_n}), 96'b001);
        for (int j = 10; j <= 30; j++) begin
            step();
            chk("abort_measure_quiet{val,irq,busy}", 96'({reg_write_valid, irq, busy}), 96'b000);
        end
        chk("abort_measure_count", 96'(measurement_count), 96'd0);

        // Abort during a stalled WRITE: the pending write completes first
        do_reset();
        reg_write_ready = 1'b0;
        arm_pulse();
        step_to(16);
        chk("stalled_valid", 96'(reg_write_valid), 96'd1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("abort_write_held{val,busy,num}", 96'({reg_write_valid, busy, reg_number}), 96'({1'b1, 1'b1, 8'd1}));
        chk("abort_write_value", 96'(reg_value), 96'(mux_val(0)));
        reg_write_ready = 1'b1;
        step();
        chk("abort_write_done{val,busy,irq}", 96'({reg_write_valid, busy, irq}), 96'b000);
        for (int j = 21; j <= 35; j++) begin
            step();
            chk("abort_write_quiet{val,irq}", 96'({reg_write_valid, irq}), 96'b00);
        end
        chk("abort_write_count", 96'(measurement_count), 96'd0);

        // Continuous mode, W=5 then window_cycles=20 mid-run
        do_reset();
        continuous = 1'b1;
        window_cycles = 32'd5;
        arm_pulse();
        step_to(9);
        chk("cont_en_last", 96'(analyzer_enable), 96'd1);
        step();
        chk("cont_en_off", 96'(analyzer_enable), 96'd0);
        step_to(13);
        window_cycles = 32'd20;
        step_to(23);
        chk("cont_irq_pre", 96'(irq), 96'd0);
        step();
        chk("cont_irq1{irq,count}", 96'({irq, measurement_count}), 96'({1'b1, 16'd1}));
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("cont_rearm{irq,clr,busy}", 96'({irq, analyzer_clear_n, busy}), 96'b001);
        step_to(48);
        chk("cont_en2_last", 96'(analyzer_enable), 96'd1);
        step();
        chk("cont_en2_off", 96'(analyzer_enable), 96'd0);
        step_to(62);
        chk("cont_irq2_pre", 96'(irq), 96'd0);
        step();
        chk("cont_irq2{irq,count}", 96'({irq, measurement_count}), 96'({1'b1, 16'd2}));
        continuous = 1'b0;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("cont_stop{irq,busy}", 96'({irq, busy}), 96'b00);

        // Zero window ignored; abort beats arm in IDLE
        do_reset();
        window_cycles = 32'd0;
        arm_pulse();
        chk("zero_window{busy,clr}", 96'({busy, analyzer_clear_n}), 96'b01);
        window_cycles = 32'd10;
        abort = 1'b1;
        arm_pulse();
        abort = 1'b0;
        chk("abort_over_arm_busy", 96'(busy), 96'd0);

        // Overrun: arm during MEASURE, arm with ack in DONE, cleared by next accepted arm
        do_reset();
        arm_pulse();
        chk("overrun_start", 96'(overrun), 96'd0);
        step_to(7);
        arm_pulse();
        chk("overrun_set{ovr,busy}", 96'({overrun, busy}), 96'b11);
        step_to(16);
        chk("overrun_run_continues", 96'(reg_write_valid), 96'd1);
        step_to(29);
        chk("overrun_irq", 96'(irq), 96'd1);
        irq_ack = 1'b1;
        arm_pulse();
        irq_ack = 1'b0;
        chk("arm_ack_done{busy,irq,ovr}", 96'({busy, irq, overrun}), 96'b001);
        chk("arm_ack_count", 96'(measurement_count), 96'd1);
        arm_pulse();
        chk("overrun_cleared{ovr,clr,busy}", 96'({overrun, analyzer_clear_n, busy}), 96'b001);

        // Asynchronous reset in the middle of a write
        do_reset();
        reg_write_ready = 1'b0;
        arm_pulse();
        step_to(16);
        chk("pre_reset_valid", 96'(reg_write_valid), 96'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 96'({analyzer_clear_n, analyzer_enable, result_index, reg_write_valid,
                                        reg_number, reg_value, irq, busy, overrun, measurement_count}),
            96'({1'b1, 1'b0, 4'd0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}));
        step();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/frequency_analysis_scheduler.md
Name: frequency_analysis_scheduler

Overview:
- Sequences one or more measurement windows for the frequency analyzer bank:
  - clears the analyzers;
  - enables them for a programmed number of clock cycles;
  - drains each result word into the register bank through a valid/ready write handshake;
  - raises an interrupt once the results are written.
- Sits between the control logic (arm/abort/ack) and the analyzers plus the register writer, and replaces the free-running start/stop gating and fixed hold-count write loop.

Parameters:
- RESULTS_NUMBER, 7, result words per window (1..15).
- REGISTER_BASE, 1, register number written for result index 0.
- CLEAR_CYCLES, 4, cycles analyzer_clear_n is held low before each window (1..255).
- WINDOW_WIDTH, 32, width of window_cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  start-request level, sampled each cycle.
- abort  in  1  cancel the current run.
- continuous  in  1  re-arm automatically after irq_ack.
- window_cycles  in  WINDOW_WIDTH  measurement length in clock cycles, latched on accepted arm.
- analyzer_clear_n  out  1  active-low clear to the analyzers.
- analyzer_enable  out  1  analyzer enable.
- result_index  out  4  selects the result word on the external mux.
- result_data  in  32  selected result word.
- reg_write_valid  out  1  write request.
- reg_write_ready  in  1  write accepted.
- reg_number  out  8  target register number.
- reg_value  out  32  data to write.
- irq  out  1  level interrupt: results written.
- irq_ack  in  1  clears irq.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky: arm seen while busy.
- measurement_count  out  16  completed windows, wraps 0xFFFF->0.

Behaviour:
- Reset values (asynchronous, while reset=1): state IDLE, all outputs 0 except analyzer_clear_n=1; internal counters 0.
- All outputs are registered.
- IDLE:
  - arm=1, abort=0, window_cycles!=0 -> latch window, go to CLEAR, clear overrun.
  - arm with window_cycles=0 is ignored.
  - abort has priority over arm.
- CLEAR:
  - analyzer_clear_n=0 for exactly CLEAR_CYCLES cycles, then MEASURE.
- MEASURE:
  - analyzer_enable=1 for exactly the latched window count of cycles, counted down from window-1 to 0.
  - Enters FETCH with index=0.
- FETCH:
  - result_index=index for 1 cycle (mux settle), then WRITE.
- WRITE:
  - reg_write_valid=1, reg_number=REGISTER_BASE+index, reg_value=result_data captured on WRITE entry.
  - valid, number and value stay stable until reg_write_ready=1.
  - On handshake: index==RESULTS_NUMBER-1 -> DONE; otherwise index+1 -> FETCH.
  - valid drops the cycle after the handshake.
- DONE:
  - irq=1 and measurement_count+1 on entry.
  - On irq_ack: irq=0; continuous=1 and abort=0 -> CLEAR (re-latch window_cycles), otherwise -> IDLE.
- Latency: arm sampled at edge k ->
  - clear low cycles k+1..k+C;
  - enable high k+C+1..k+C+W;
  - first valid at k+C+W+2;
  - irq at k+C+W+2N+1, with ready held high.
- Abort:
  - In CLEAR, MEASURE or FETCH: go to IDLE next cycle, no writes, no irq, count unchanged.
  - In WRITE: the pending write is held until handshake (valid is never withdrawn), then IDLE, no irq.
  - In DONE: go to IDLE, irq=0.
- arm while busy: ignored, overrun=1 (sticky until the next accepted arm).
- irq_ack outside DONE is ignored.
- arm and irq_ack in DONE in the same cycle: ack processed, arm counts as overrun.
- Changes to window_cycles during a run have no effect.
- reset asserted mid-write drops valid immediately.

Test Plan:
- C=4, W=10, N=7, ready=1, arm pulse at cycle 0 -> clear_n low cycles 1-4; enable high 5-14; valid at 16,18,…,28 with reg_number 1..7 and reg_value = mux data for index 0..6; irq=1 at 29; measurement_count=1.
- Same run with ready low for 3 cycles on each write -> valid/number/value stable across stalls; irq at 29+21=50.
- abort at cycle 8 (MEASURE) -> enable=0 at 9, IDLE, no valid, irq=0, count=0; abort during a stalled WRITE -> that write completes, then IDLE, no irq.
- continuous=1, W=5 -> after irq_ack, next CLEAR starts the following cycle; two acks give count=2; window_cycles changed to 20 mid-run takes effect only in the second window.
- window_cycles=0 with arm -> stays IDLE, busy=0; arm during MEASURE -> overrun=1, ignored, cleared by the next accepted arm.
- reset asserted during WRITE -> all outputs return to reset values immediately, without a clock edge.
